// File: rtl/status_frame_receiver.sv
// status_frame_receiver: finds 0xB000B135-led hand-status frames in a uart byte stream,
// checks the payload CRC16 and presents decoded, sign-extended fields. Optional macro: MOTOR_ID_FILTER_EN.
module status_frame_receiver #(
    parameter int unsigned CLK_FREQ_HZ         = 50_000_000,
    parameter int unsigned BYTE_TIMEOUT_CYCLES = 100_000,
    parameter logic [31:0] MAGIC               = 32'hB000B135,
    parameter int unsigned PAYLOAD_LEN         = 31
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_data_ready,
    input  logic [7:0]  rx_data,
    input  logic        abort,
`ifdef MOTOR_ID_FILTER_EN
    input  logic [7:0]  expected_id,
    output logic        id_mismatch,
`endif
    output logic        busy,
    output logic        frame_valid,
    output logic        crc_error,
    output logic        timeout_error,
    output logic [7:0]  motor_id,
    output logic [7:0]  control_mode,
    output logic [31:0] encoder0_position,
    output logic [31:0] encoder1_position,
    output logic [31:0] setpoint_actual,
    output logic [31:0] duty,
    output logic [15:0] current,
    output logic [15:0] frame_count,
    output logic [15:0] error_count
);

    localparam int unsigned        TIMER_W    = $clog2(BYTE_TIMEOUT_CYCLES + 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(BYTE_TIMEOUT_CYCLES - 1);
    localparam logic [4:0]         IDX_CRC_HI = 5'(PAYLOAD_LEN - 2);
    localparam logic [4:0]         IDX_LAST   = 5'(PAYLOAD_LEN - 1);

    if (CLK_FREQ_HZ == 0 || PAYLOAD_LEN != 31 || BYTE_TIMEOUT_CYCLES < 2) begin : g_bad_cfg
        $error("status_frame_receiver: unsupported parameter set");
    end

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_CHECK   = 2'd2
    } state_t;

    // CRC16 poly 0x8005, MSB first, one byte per call
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in, input logic [7:0] data);
        logic [15:0] c;
        c = crc_in;
        for (int i = 7; i >= 0; i--) begin
            if (c[15] ^ data[i]) begin
                c = {c[14:0], 1'b0} ^ 16'h8005;
            end else begin
                c = {c[14:0], 1'b0};
            end
        end
        return c;
    endfunction

    function automatic logic [31:0] sext24(input logic [23:0] v);
        return {{8{v[23]}}, v};
    endfunction

    state_t              state_q, state_d;
    logic [23:0]         sr_q, sr_d;
    logic [4:0]          idx_q, idx_d;
    logic [TIMER_W-1:0]  timer_q, timer_d;
    logic [15:0]         crc_q, crc_d;
    logic [13:0][7:0]    hdr_q, hdr_d;
    logic [15:0]         cur_q, cur_d;
    logic [15:0]         crc_rx_q, crc_rx_d;

    logic                frame_valid_q, frame_valid_d;
    logic                crc_error_q, crc_error_d;
    logic                timeout_error_q, timeout_error_d;
    logic [7:0]          motor_id_q, motor_id_d;
    logic [7:0]          control_mode_q, control_mode_d;
    logic [31:0]         encoder0_position_q, encoder0_position_d;
    logic [31:0]         encoder1_position_q, encoder1_position_d;
    logic [31:0]         setpoint_actual_q, setpoint_actual_d;
    logic [31:0]         duty_q, duty_d;
    logic [15:0]         current_q, current_d;
    logic [15:0]         frame_count_q, frame_count_d;
    logic [15:0]         error_count_q, error_count_d;

    logic                magic_hit_s;
    logic                timeout_s;
    logic                take_byte_s;
    logic                crc_ok_s;
    logic [15:0]         err_sat_inc_s;

    assign magic_hit_s   = rx_data_ready && ({sr_q, rx_data} == MAGIC);
    assign timeout_s     = abort || (timer_q == TIMER_LAST);
    // abort or timeout in the same cycle as a strobe drops that byte
    assign take_byte_s   = rx_data_ready && !timeout_s;
    assign crc_ok_s      = (crc_rx_q == crc_q);
    assign err_sat_inc_s = (error_count_q == 16'hFFFF) ? error_count_q : (error_count_q + 16'd1);

`ifdef MOTOR_ID_FILTER_EN
    logic id_mismatch_q, id_mismatch_d;
    logic id_ok_s;
    assign id_ok_s     = (hdr_q[0] == expected_id);
    assign id_mismatch = id_mismatch_q;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_HUNT: begin
                if (magic_hit_s) begin
                    state_d = ST_PAYLOAD;
                end else begin
                    state_d = ST_HUNT;
                end
            end
            ST_PAYLOAD: begin
                if (timeout_s) begin
                    state_d = ST_HUNT;
                end else if (take_byte_s && (idx_q == IDX_LAST)) begin
                    state_d = ST_CHECK;
                end else begin
                    state_d = ST_PAYLOAD;
                end
            end
            ST_CHECK: state_d = ST_HUNT;
            default:  state_d = ST_HUNT;
        endcase
    end

    // Datapath and output next values
    always_comb begin
        sr_d                = sr_q;
        idx_d               = idx_q;
        timer_d             = timer_q;
        crc_d               = crc_q;
        hdr_d               = hdr_q;
        cur_d               = cur_q;
        crc_rx_d            = crc_rx_q;
        frame_valid_d       = 1'b0;
        crc_error_d         = 1'b0;
        timeout_error_d     = 1'b0;
`ifdef MOTOR_ID_FILTER_EN
        id_mismatch_d       = 1'b0;
`endif
        motor_id_d          = motor_id_q;
        control_mode_d      = control_mode_q;
        encoder0_position_d = encoder0_position_q;
        encoder1_position_d = encoder1_position_q;
        setpoint_actual_d   = setpoint_actual_q;
        duty_d              = duty_q;
        current_d           = current_q;
        frame_count_d       = frame_count_q;
        error_count_d       = error_count_q;
        case (state_q)
            ST_HUNT: begin
                if (magic_hit_s) begin
                    sr_d    = 24'd0;
                    idx_d   = 5'd0;
                    timer_d = '0;
                    crc_d   = 16'hFFFF;
                end else if (rx_data_ready) begin
                    sr_d = {sr_q[15:0], rx_data};
                end else begin
                    sr_d = sr_q;
                end
            end
            ST_PAYLOAD: begin
                if (timeout_s) begin
                    timeout_error_d = 1'b1;
                    error_count_d   = err_sat_inc_s;
                    timer_d         = '0;
                end else if (take_byte_s) begin
                    if (idx_q < 5'd14) begin
                        hdr_d[idx_q[3:0]] = rx_data;
                    end else if (idx_q == 5'd17) begin
                        cur_d[15:8] = rx_data;
                    end else if (idx_q == 5'd18) begin
                        cur_d[7:0] = rx_data;
                    end else if (idx_q == IDX_CRC_HI) begin
                        crc_rx_d[15:8] = rx_data;
                    end else if (idx_q == IDX_LAST) begin
                        crc_rx_d[7:0] = rx_data;
                    end else begin
                        hdr_d = hdr_q;
                    end
                    if (idx_q < IDX_CRC_HI) begin
                        crc_d = crc16_byte(crc_q, rx_data);
                    end else begin
                        crc_d = crc_q;
                    end
                    idx_d   = idx_q + 5'd1;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            ST_CHECK: begin
                if (rx_data_ready) begin
                    sr_d = {sr_q[15:0], rx_data};
                end else begin
                    sr_d = sr_q;
                end
                if (!crc_ok_s) begin
                    crc_error_d   = 1'b1;
                    error_count_d = err_sat_inc_s;
`ifdef MOTOR_ID_FILTER_EN
                end else if (!id_ok_s) begin
                    id_mismatch_d = 1'b1;
`endif
                end else begin
                    frame_valid_d       = 1'b1;
                    frame_count_d       = frame_count_q + 16'd1;
                    motor_id_d          = hdr_q[0];
                    control_mode_d      = hdr_q[1];
                    encoder0_position_d = sext24({hdr_q[2], hdr_q[3], hdr_q[4]});
                    encoder1_position_d = sext24({hdr_q[5], hdr_q[6], hdr_q[7]});
                    setpoint_actual_d   = sext24({hdr_q[8], hdr_q[9], hdr_q[10]});
                    duty_d              = sext24({hdr_q[11], hdr_q[12], hdr_q[13]});
                    current_d           = cur_q;
                end
            end
            default: begin
                sr_d = sr_q;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            sr_q                <= 24'd0;
            idx_q               <= 5'd0;
            timer_q             <= '0;
            crc_q               <= 16'hFFFF;
            hdr_q               <= '0;
            cur_q               <= 16'd0;
            crc_rx_q            <= 16'd0;
            frame_valid_q       <= 1'b0;
            crc_error_q         <= 1'b0;
            timeout_error_q     <= 1'b0;
`ifdef MOTOR_ID_FILTER_EN
            id_mismatch_q       <= 1'b0;
`endif
            motor_id_q          <= 8'd0;
            control_mode_q      <= 8'd0;
            encoder0_position_q <= 32'd0;
            encoder1_position_q <= 32'd0;
            setpoint_actual_q   <= 32'd0;
            duty_q              <= 32'd0;
            current_q           <= 16'd0;
            frame_count_q       <= 16'd0;
            error_count_q       <= 16'd0;
        end else begin
            sr_q                <= sr_d;
            idx_q               <= idx_d;
            timer_q             <= timer_d;
            crc_q               <= crc_d;
            hdr_q               <= hdr_d;
            cur_q               <= cur_d;
            crc_rx_q            <= crc_rx_d;
            frame_valid_q       <= frame_valid_d;
            crc_error_q         <= crc_error_d;
            timeout_error_q     <= timeout_error_d;
`ifdef MOTOR_ID_FILTER_EN
            id_mismatch_q       <= id_mismatch_d;
`endif
            motor_id_q          <= motor_id_d;
            control_mode_q      <= control_mode_d;
            encoder0_position_q <= encoder0_position_d;
            encoder1_position_q <= encoder1_position_d;
            setpoint_actual_q   <= setpoint_actual_d;
            duty_q              <= duty_d;
            current_q           <= current_d;
            frame_count_q       <= frame_count_d;
            error_count_q       <= error_count_d;
        end
    end

    assign busy              = (state_q != ST_HUNT);
    assign frame_valid       = frame_valid_q;
    assign crc_error         = crc_error_q;
    assign timeout_error     = timeout_error_q;
    assign motor_id          = motor_id_q;
    assign control_mode      = control_mode_q;
    assign encoder0_position = encoder0_position_q;
    assign encoder1_position = encoder1_position_q;
    assign setpoint_actual   = setpoint_actual_q;
    assign duty              = duty_q;
    assign current           = current_q;
    assign frame_count       = frame_count_q;
    assign error_count       = error_count_q;

endmodule

// File: tb/tb_status_frame_receiver.sv
// Self-checking bench for status_frame_receiver: randomized frames against a behavioural
// frame/CRC model (CRC by polynomial long division over the whole payload bit string).
module tb_status_frame_receiver;

    localparam int TO = 300;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_data_ready;
    logic [7:0]  rx_data;
    logic        abort;
    logic        busy, frame_valid, crc_error, timeout_error;
    logic [7:0]  motor_id, control_mode;
    logic [31:0] encoder0_position, encoder1_position, setpoint_actual, duty;
    logic [15:0] current, frame_count, error_count;
`ifdef MOTOR_ID_FILTER_EN
    logic [7:0]  expected_id;
    logic        id_mismatch;
    wire         idm_s = id_mismatch;
`else
    wire         idm_s = 1'b0;
`endif

    always #5 clk = ~clk;

    status_frame_receiver #(.BYTE_TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .rx_data_ready(rx_data_ready), .rx_data(rx_data), .abort(abort),
`ifdef MOTOR_ID_FILTER_EN
        .expected_id(expected_id), .id_mismatch(id_mismatch),
`endif
        .busy(busy), .frame_valid(frame_valid), .crc_error(crc_error), .timeout_error(timeout_error),
        .motor_id(motor_id), .control_mode(control_mode),
        .encoder0_position(encoder0_position), .encoder1_position(encoder1_position),
        .setpoint_actual(setpoint_actual), .duty(duty), .current(current),
        .frame_count(frame_count), .error_count(error_count)
    );

    wire [3:0]   pulses = {frame_valid, crc_error, timeout_error, idm_s};
    wire [191:0] flds   = {motor_id, control_mode, encoder0_position, encoder1_position,
                           setpoint_actual, duty, current, frame_count, error_count};

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0]  pl [0:30];
    logic [7:0]  m_id, m_mode;
    logic [31:0] m_e0, m_e1, m_sp, m_du;
    logic [15:0] m_cur, m_fc, m_ec;

    logic         ob_a_busy, ob_b_busy;
    logic [3:0]   ob_a_pul, ob_b_pul;
    logic [191:0] ob_b_flds;

    function automatic logic [191:0] exp_flds();
        return {m_id, m_mode, m_e0, m_e1, m_sp, m_du, m_cur, m_fc, m_ec};
    endfunction

    function automatic logic [31:0] s24(input int hi, input int mid, input int lo);
        int v;
        v = hi * 65536 + mid * 256 + lo;
        if (v >= 8388608) v = v - 16777216;
        return 32'(v);
    endfunction

    // CRC over payload bytes 0..28: init folded into the first 16 message bits, then long division
    function automatic logic [15:0] model_crc();
        bit          bits[$];
        logic [16:0] poly = 17'h18005;
        logic [15:0] r;
        int          last;
        for (int i = 0; i < 29; i++)
            for (int b = 7; b >= 0; b--) bits.push_back(pl[i][b]);
        for (int i = 0; i < 16; i++) bits[i] = ~bits[i];
        repeat (16) bits.push_back(1'b0);
        last = bits.size() - 16;
        for (int i = 0; i < last; i++)
            if (bits[i])
                for (int j = 0; j <= 16; j++) bits[i+j] = bits[i+j] ^ poly[16-j];
        for (int k = 0; k < 16; k++) r[15-k] = bits[last+k];
        return r;
    endfunction

    task automatic seal_crc();
        logic [15:0] c;
        c = model_crc();
        pl[29] = c[15:8];
        pl[30] = c[7:0];
    endtask

    task automatic set_expect(input logic [7:0] id);
`ifdef MOTOR_ID_FILTER_EN
        expected_id = id;
`endif
    endtask

    task automatic make_payload(input logic [7:0] id, input logic [7:0] mode, input logic [23:0] e0,
                                input logic [23:0] e1, input logic [23:0] sp, input logic [23:0] du,
                                input logic [15:0] cur);
        for (int i = 0; i < 31; i++) pl[i] = 8'($urandom);
        pl[0] = id; pl[1] = mode;
        {pl[2], pl[3], pl[4]}    = e0;
        {pl[5], pl[6], pl[7]}    = e1;
        {pl[8], pl[9], pl[10]}   = sp;
        {pl[11], pl[12], pl[13]} = du;
        {pl[17], pl[18]}         = cur;
        seal_crc();
        set_expect(id);
    endtask

    task automatic random_payload();
        make_payload(8'($urandom), 8'($urandom), 24'($urandom), 24'($urandom),
                     24'($urandom), 24'($urandom), 16'($urandom));
    endtask

    task automatic model_accept();
        m_id = pl[0]; m_mode = pl[1];
        m_e0 = s24(pl[2], pl[3], pl[4]);
        m_e1 = s24(pl[5], pl[6], pl[7]);
        m_sp = s24(pl[8], pl[9], pl[10]);
        m_du = s24(pl[11], pl[12], pl[13]);
        m_cur = 16'(pl[17] * 256 + pl[18]);
        m_fc = m_fc + 16'd1;
    endtask

    task automatic model_error();
        if (m_ec != 16'hFFFF) m_ec = m_ec + 16'd1;
    endtask

    task automatic model_reset();
        m_id = 8'd0; m_mode = 8'd0; m_e0 = 32'd0; m_e1 = 32'd0; m_sp = 32'd0; m_du = 32'd0;
        m_cur = 16'd0; m_fc = 16'd0; m_ec = 16'd0;
    endtask

    task automatic drive_byte(input logic [7:0] b, input int gap);
        rx_data = b; rx_data_ready = 1'b1;
        @(negedge clk);
        rx_data_ready = 1'b0; rx_data = 8'($urandom);
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_magic();
        logic [31:0] mg = 32'hB000B135;
        for (int i = 3; i >= 0; i--) drive_byte(mg[i*8 +: 8], $urandom_range(0, 2));
    endtask

    // Sends a whole payload; observes the CHECK cycle (a) and the result cycle (b)
    task automatic run_frame(input bit with_magic);
        if (with_magic) send_magic();
        for (int i = 0; i < 30; i++) drive_byte(pl[i], $urandom_range(0, 3));
        drive_byte(pl[30], 0);
        ob_a_busy = busy; ob_a_pul = pulses;
        @(negedge clk);
        ob_b_pul = pulses; ob_b_flds = flds; ob_b_busy = busy;
    endtask

    task automatic test_reset();
        reset = 1'b1; abort = 1'b0; rx_data_ready = 1'b0; rx_data = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        model_reset();
        n_cmp++; if (flds !== exp_flds()) begin n_err++; $display("FAIL reset_fields: got %h expected %h", flds, exp_flds()); end
        n_cmp++; if (pulses !== 4'b0000) begin n_err++; $display("FAIL reset_pulses: got %b expected 0000", pulses); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
    endtask

    task automatic test_frame();
        make_payload(8'h03, 8'h01, 24'hFFFFFE, 24'h000010, 24'h000100, 24'h7FFFFF, 16'h0123);
        run_frame(1'b1);
        model_accept();
        n_cmp++; if ({ob_a_busy, ob_a_pul} !== 5'b1_0000) begin n_err++; $display("FAIL frame_check_cycle: got busy/pulses %b expected 1_0000", {ob_a_busy, ob_a_pul}); end
        n_cmp++; if ({ob_b_busy, ob_b_pul} !== 5'b0_1000) begin n_err++; $display("FAIL frame_valid_n2: got busy/pulses %b expected 0_1000", {ob_b_busy, ob_b_pul}); end
        n_cmp++; if (ob_b_flds !== exp_flds()) begin n_err++; $display("FAIL frame_fields: got %h expected %h", ob_b_flds, exp_flds()); end
        n_cmp++; if ({encoder0_position, encoder1_position, setpoint_actual, duty, current, frame_count} !==
                     {32'hFFFFFFFE, 32'h00000010, 32'h00000100, 32'h007FFFFF, 16'h0123, 16'h0001}) begin
            n_err++; $display("FAIL frame_vector: got %h %h %h %h %h %h", encoder0_position, encoder1_position,
                              setpoint_actual, duty, current, frame_count);
        end
    endtask

    task automatic test_corrupt_crc();
        pl[30] = pl[30] ^ 8'h01;
        run_frame(1'b1);
        model_error();
        n_cmp++; if (ob_b_pul !== 4'b0100) begin n_err++; $display("FAIL crc_error_pulse: got %b expected 0100", ob_b_pul); end
        n_cmp++; if (ob_b_flds !== exp_flds()) begin n_err++; $display("FAIL crc_fields_kept: got %h expected %h", ob_b_flds, exp_flds()); end
    endtask

    task automatic test_random_frames();
        for (int n = 0; n < 6; n++) begin
            random_payload();
            run_frame(1'b1);
            model_accept();
            n_cmp++; if (ob_b_pul !== 4'b1000) begin n_err++; $display("FAIL random_pulse[%0d]: got %b expected 1000", n, ob_b_pul); end
            n_cmp++; if (ob_b_flds !== exp_flds()) begin n_err++; $display("FAIL random_fields[%0d]: got %h expected %h", n, ob_b_flds, exp_flds()); end
        end
    endtask

    task automatic test_resync();
        logic [47:0] junk = 48'hB000B000B135;
        random_payload();
        {pl[19], pl[20], pl[21], pl[22]} = 32'hB000B135;
        seal_crc();
        for (int i = 5; i >= 0; i--) drive_byte(junk[i*8 +: 8], $urandom_range(0, 2));
        run_frame(1'b0);
        model_accept();
        n_cmp++; if (ob_b_pul !== 4'b1000) begin n_err++; $display("FAIL resync_pulse: got %b expected 1000", ob_b_pul); end
        n_cmp++; if (ob_b_flds !== exp_flds()) begin n_err++; $display("FAIL resync_fields: got %h expected %h", ob_b_flds, exp_flds()); end
    endtask

    task automatic test_timeout();
        int k;
        random_payload();
        send_magic();
        for (int i = 0; i < 9; i++) drive_byte(pl[i], (i == 4) ? TO - 2 : $urandom_range(0, 3));
        drive_byte(pl[9], 0);
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL timeout_long_gap_busy: got %b expected 1", busy); end
        for (k = 0; k < 2 * TO && !timeout_error; k++) @(negedge clk);
        model_error();
        n_cmp++; if (k !== TO) begin n_err++; $display("FAIL timeout_latency: got %0d cycles expected %0d", k, TO); end
        n_cmp++; if ({busy, pulses} !== 5'b0_0010) begin n_err++; $display("FAIL timeout_pulse: got busy/pulses %b expected 0_0010", {busy, pulses}); end
        n_cmp++; if (flds !== exp_flds()) begin n_err++; $display("FAIL timeout_fields: got %h expected %h", flds, exp_flds()); end
        random_payload();
        run_frame(1'b1);
        model_accept();
        n_cmp++; if ({ob_b_pul, ob_b_flds} !== {4'b1000, exp_flds()}) begin n_err++; $display("FAIL timeout_next_frame: got %b %h expected 1000 %h", ob_b_pul, ob_b_flds, exp_flds()); end
    endtask

    task automatic test_abort();
        int seen;
        random_payload();
        send_magic();
        for (int i = 0; i < 20; i++) drive_byte(pl[i], $urandom_range(0, 3));
        abort = 1'b1; rx_data = pl[20]; rx_data_ready = 1'b1;
        @(negedge clk);
        abort = 1'b0; rx_data_ready = 1'b0;
        model_error();
        n_cmp++; if ({busy, pulses} !== 5'b0_0010) begin n_err++; $display("FAIL abort_pulse: got busy/pulses %b expected 0_0010", {busy, pulses}); end
        n_cmp++; if (flds !== exp_flds()) begin n_err++; $display("FAIL abort_fields: got %h expected %h", flds, exp_flds()); end
        seen = 0;
        abort = 1'b1;
        repeat (4) begin @(negedge clk); if (pulses != 4'b0000 || busy) seen++; end
        abort = 1'b0;
        n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL abort_in_hunt: got %0d active cycles expected 0", seen); end
        run_frame(1'b1);
        model_accept();
        n_cmp++; if ({ob_b_pul, ob_b_flds} !== {4'b1000, exp_flds()}) begin n_err++; $display("FAIL abort_next_frame: got %b %h expected 1000 %h", ob_b_pul, ob_b_flds, exp_flds()); end
    endtask

    task automatic test_reset_mid();
        random_payload();
        send_magic();
        for (int i = 0; i < 15; i++) drive_byte(pl[i], $urandom_range(0, 3));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        n_cmp++; if ({busy, pulses, flds} !== {5'b0_0000, exp_flds()}) begin n_err++; $display("FAIL reset_mid_outputs: got %b %h expected all zero", {busy, pulses}, flds); end
        random_payload();
        run_frame(1'b1);
        model_accept();
        n_cmp++; if ({ob_b_pul, ob_b_flds} !== {4'b1000, exp_flds()}) begin n_err++; $display("FAIL reset_next_frame: got %b %h expected 1000 %h", ob_b_pul, ob_b_flds, exp_flds()); end
    endtask

    task automatic test_back_to_back();
        random_payload();
        send_magic();
        for (int i = 0; i < 30; i++) drive_byte(pl[i], $urandom_range(0, 3));
        drive_byte(pl[30], 0);
        rx_data = 8'hB0; rx_data_ready = 1'b1;
        @(negedge clk);
        rx_data_ready = 1'b0;
        model_accept();
        n_cmp++; if ({pulses, flds} !== {4'b1000, exp_flds()}) begin n_err++; $display("FAIL b2b_first: got %b %h expected 1000 %h", pulses, flds, exp_flds()); end
        drive_byte(8'h00, 0); drive_byte(8'hB1, 1); drive_byte(8'h35, 0);
        random_payload();
        run_frame(1'b0);
        model_accept();
        n_cmp++; if ({ob_b_pul, ob_b_flds} !== {4'b1000, exp_flds()}) begin n_err++; $display("FAIL b2b_second: got %b %h expected 1000 %h", ob_b_pul, ob_b_flds, exp_flds()); end
    endtask

    task automatic test_saturation();
        force dut.error_count_q = 16'hFFFF;
        #1;
        release dut.error_count_q;
        m_ec = 16'hFFFF;
        @(negedge clk);
        n_cmp++; if (error_count !== 16'hFFFF) begin n_err++; $display("FAIL sat_preload: got %h expected FFFF", error_count); end
        random_payload();
        pl[30] = pl[30] ^ 8'h01;
        run_frame(1'b1);
        model_error();
        n_cmp++; if ({ob_b_pul, ob_b_flds} !== {4'b0100, exp_flds()}) begin n_err++; $display("FAIL sat_hold: got %b %h expected 0100 %h", ob_b_pul, ob_b_flds, exp_flds()); end
    endtask

`ifdef MOTOR_ID_FILTER_EN
    task automatic test_id_filter();
        make_payload(8'h03, 8'($urandom), 24'($urandom), 24'($urandom), 24'($urandom), 24'($urandom), 16'($urandom));
        expected_id = 8'h05;
        run_frame(1'b1);
        n_cmp++; if ({ob_b_pul, ob_b_flds} !== {4'b0001, exp_flds()}) begin n_err++; $display("FAIL id_mismatch: got %b %h expected 0001 %h", ob_b_pul, ob_b_flds, exp_flds()); end
        expected_id = 8'h03;
        run_frame(1'b1);
        model_accept();
        n_cmp++; if ({ob_b_pul, ob_b_flds} !== {4'b1000, exp_flds()}) begin n_err++; $display("FAIL id_match: got %b %h expected 1000 %h", ob_b_pul, ob_b_flds, exp_flds()); end
    endtask
`endif

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; abort = 1'b0; rx_data_ready = 1'b0; rx_data = 8'h00;
        set_expect(8'h00);
        @(negedge clk);
        test_reset();
        test_frame();
        test_corrupt_crc();
        test_random_frames();
        test_resync();
        test_timeout();
        test_abort();
        test_reset_mid();
        test_back_to_back();
`ifdef MOTOR_ID_FILTER_EN
        test_id_filter();
`endif
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
